// File: rtl/psum_bank_arbiter.sv
// -----------------------------------------------------------------------------
// psum_bank_arbiter
//
// Purpose:
//   Shares one single-port psum SRAM bank between two requesters:
//     - SFU writeback (valid/ready). It normally wins arbitration.
//     - Readout requester (req/grant). It is guaranteed service once
//       MAX_WR_BURST writes have been granted while it was waiting.
//   All SRAM controls are registered. Read data comes back with a fixed
//   two-cycle latency measured from the grant.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   wr_valid_i/wr_ready_o          write handshake (ready is combinational)
//   wr_addr_i, wr_data_i           write word address / data
//   rd_req_i/rd_gnt_o              read handshake (grant is combinational)
//   rd_addr_i                      read word address
//   rd_data_o, rd_data_valid_o     read return (data gated to 0 when not valid)
//   addr_err_o                     1-cycle pulse for an accepted out-of-range access
//   mem_cen_n_o, mem_wen_n_o       SRAM enables, active-low, registered
//   mem_addr_o, mem_data_o         SRAM address / write data, registered
//   mem_data_i                     SRAM read data, valid 1 cycle after read CEN
//
// Optional feature (macro PSUM_ARB_PERF_EN):
//   Adds wr_cnt_o, rd_cnt_o, stall_cnt_o: saturating 16-bit counters of
//   accepted writes, accepted reads and stalled cycles.
// -----------------------------------------------------------------------------
module psum_bank_arbiter #(
  parameter int psum_bw      = 16,
  parameter int col          = 8,
  parameter int len_onij     = 16,
  parameter int MAX_WR_BURST = 4,
  localparam int AW = (len_onij > 1) ? $clog2(len_onij) : 1,
  localparam int DW = col * psum_bw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_req_i,
  output logic          rd_gnt_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_data_valid_o,
  output logic          addr_err_o,
  output logic          mem_cen_n_o,
  output logic          mem_wen_n_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i
`ifdef PSUM_ARB_PERF_EN
  ,
  output logic [15:0]   wr_cnt_o,
  output logic [15:0]   rd_cnt_o,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam int SW = (MAX_WR_BURST > 0) ? $clog2(MAX_WR_BURST + 1) : 1;
  localparam logic [SW-1:0] BURST_LAST = SW'(MAX_WR_BURST);
  // One extra bit so a power-of-2 depth is representable for the compare.
  localparam logic [AW:0]   DEPTH      = (AW + 1)'(len_onij);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SW-1:0] streak_q, streak_d;
  logic          rd_pri_q, rd_pri_d;
  logic          cen_n_q, cen_n_d;
  logic          wen_n_q, wen_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          rd_issue_q, rd_issue_d;   // read command on the SRAM pins now
  logic          rd_valid_q, rd_valid_d;   // SRAM read data on mem_data_i now

  logic          wr_gnt, rd_gnt;
  logic          wr_in_range, rd_in_range;
  logic          wr_fire, rd_fire;
  logic [SW-1:0] streak_inc;

  // ---------------------------------------------------------------------------
  // Arbitration: a starved reader beats the writer, otherwise writes win.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rd_pri_q && rd_req_i) begin
      rd_gnt = 1'b1;
    end else if (wr_valid_i) begin
      wr_gnt = 1'b1;
    end else if (rd_req_i) begin
      rd_gnt = 1'b1;
    end
  end

  assign wr_ready_o = wr_gnt;
  assign rd_gnt_o   = rd_gnt;

  // Out-of-range requests are still consumed, only their SRAM access is dropped.
  assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH);
  assign wr_fire     = wr_gnt && wr_in_range;
  assign rd_fire     = rd_gnt && rd_in_range;

  // ---------------------------------------------------------------------------
  // Starvation bound. The streak only counts writes that overtook a waiting
  // reader; once it reaches MAX_WR_BURST the reader gets priority, which is
  // held until it is actually granted.
  // ---------------------------------------------------------------------------
  assign streak_inc = streak_q + SW'(1);

  always_comb begin
    streak_d = streak_q;
    rd_pri_d = rd_pri_q;
    if (rd_gnt || !rd_req_i) begin
      streak_d = '0;
    end else if (wr_gnt) begin
      streak_d = streak_inc;
    end
    if (rd_gnt) begin
      rd_pri_d = 1'b0;
    end else if (wr_gnt && rd_req_i && (streak_inc == BURST_LAST)) begin
      rd_pri_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM command register. Address and data hold when idle so the macro pins
  // only toggle on real accesses.
  // ---------------------------------------------------------------------------
  always_comb begin
    cen_n_d    = !(wr_fire || rd_fire);
    wen_n_d    = !wr_fire;
    addr_d     = addr_q;
    data_d     = data_q;
    if (wr_fire) begin
      addr_d = wr_addr_i;
      data_d = wr_data_i;
    end else if (rd_fire) begin
      addr_d = rd_addr_i;
    end
    err_d      = (wr_gnt && !wr_in_range) || (rd_gnt && !rd_in_range);
    rd_issue_d = rd_fire;
    rd_valid_d = rd_issue_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q   <= '0;
      rd_pri_q   <= 1'b0;
      cen_n_q    <= 1'b1;
      wen_n_q    <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      rd_pri_q   <= rd_pri_d;
      cen_n_q    <= cen_n_d;
      wen_n_q    <= wen_n_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rd_issue_q <= rd_issue_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mem_cen_n_o     = cen_n_q;
  assign mem_wen_n_o     = wen_n_q;
  assign mem_addr_o      = addr_q;
  assign mem_data_o      = data_q;
  assign addr_err_o      = err_q;
  assign rd_data_valid_o = rd_valid_q;
  assign rd_data_o       = rd_valid_q ? mem_data_i : '0;

`ifdef PSUM_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating).
  // ---------------------------------------------------------------------------
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign stall = (wr_valid_i && !wr_gnt) || (rd_req_i && !rd_gnt);

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (wr_gnt && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (rd_gnt && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_psum_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psum_bank_arbiter
//
// Randomised and directed stimulus for psum_bank_arbiter, configured with a
// non-power-of-2 depth (12 words) so the range-error path is reachable.
// A small SRAM macro model sits on the memory pins; expected behaviour comes
// from a transaction-level reference (grant rules, a reference memory and a
// queue of expected read returns).
// -----------------------------------------------------------------------------
module tb_psum_bank_arbiter;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int LEN     = 12;
  localparam int BURST   = 4;
  localparam int AW      = 4;
  localparam int DW      = PSUM_BW * COL;

  logic          clk;
  logic          reset;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          rd_req_i;
  logic          rd_gnt_o;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_data_valid_o;
  logic          addr_err_o;
  logic          mem_cen_n_o;
  logic          mem_wen_n_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;
`ifdef PSUM_ARB_PERF_EN
  logic [15:0]   wr_cnt_o;
  logic [15:0]   rd_cnt_o;
  logic [15:0]   stall_cnt_o;
`endif

  psum_bank_arbiter #(
    .psum_bw      (PSUM_BW),
    .col          (COL),
    .len_onij     (LEN),
    .MAX_WR_BURST (BURST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .rd_req_i        (rd_req_i),
    .rd_gnt_o        (rd_gnt_o),
    .rd_addr_i       (rd_addr_i),
    .rd_data_o       (rd_data_o),
    .rd_data_valid_o (rd_data_valid_o),
    .addr_err_o      (addr_err_o),
    .mem_cen_n_o     (mem_cen_n_o),
    .mem_wen_n_o     (mem_wen_n_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_data_i      (mem_data_i)
`ifdef PSUM_ARB_PERF_EN
    ,
    .wr_cnt_o        (wr_cnt_o),
    .rd_cnt_o        (rd_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: synchronous write, registered read.
  logic [DW-1:0] sram [16];
  initial begin
    for (int i = 0; i < 16; i++) sram[i] = '0;
    mem_data_i = '0;
  end
  always @(posedge clk) begin
    if (!mem_cen_n_o) begin
      if (!mem_wen_n_o) sram[mem_addr_o] <= mem_data_o;
      else              mem_data_i <= sram[mem_addr_o];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_ret_t;

  rd_ret_t       rdq[$];
  logic [DW-1:0] ref_mem [16];
  bit            m_pri;
  int            m_streak;
  logic          exp_cen, exp_wen, exp_err;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            m_wr_cnt, m_rd_cnt, m_stall_cnt;
  bit            last_wg, last_rg;

  task automatic model_reset();
    rdq.delete();
    m_pri       = 1'b0;
    m_streak    = 0;
    exp_cen     = 1'b1;
    exp_wen     = 1'b1;
    exp_err     = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    m_wr_cnt    = 0;
    m_rd_cnt    = 0;
    m_stall_cnt = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cen"},   mem_cen_n_o,     1'b1);
    chk({tag, "_wen"},   mem_wen_n_o,     1'b1);
    chk({tag, "_addr"},  mem_addr_o,      '0);
    chk({tag, "_data"},  mem_data_o,      '0);
    chk({tag, "_valid"}, rd_data_valid_o, 1'b0);
    chk({tag, "_err"},   addr_err_o,      1'b0);
`ifdef PSUM_ARB_PERF_EN
    chk({tag, "_wcnt"},  wr_cnt_o,        '0);
    chk({tag, "_rcnt"},  rd_cnt_o,        '0);
    chk({tag, "_scnt"},  stall_cnt_o,     '0);
`endif
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: check what the previous grant produced, drive new
  // requests, check the grant and advance the reference.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit rr, input logic [AW-1:0] ra);
    bit eg_w, eg_r, exp_v;
    @(negedge clk);
    cyc++;
    chk("cen",  mem_cen_n_o, exp_cen);
    chk("wen",  mem_wen_n_o, exp_wen);
    chk("addr", mem_addr_o,  exp_addr);
    chk("data", mem_data_o,  exp_data);
    chk("err",  addr_err_o,  exp_err);
    exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
    chk("rvalid", rd_data_valid_o, exp_v);
    if (exp_v) begin
      chk("rdata", rd_data_o, rdq[0].data);
      void'(rdq.pop_front());
    end
`ifdef PSUM_ARB_PERF_EN
    chk("wr_cnt",    wr_cnt_o,    16'(m_wr_cnt));
    chk("rd_cnt",    rd_cnt_o,    16'(m_rd_cnt));
    chk("stall_cnt", stall_cnt_o, 16'(m_stall_cnt));
`endif

    wr_valid_i = wv;
    wr_addr_i  = wa;
    wr_data_i  = wd;
    rd_req_i   = rr;
    rd_addr_i  = ra;
    #1;

    // Who should win this cycle.
    eg_w = 1'b0;
    eg_r = 1'b0;
    if (rr && m_pri)  eg_r = 1'b1;
    else if (wv)      eg_w = 1'b1;
    else if (rr)      eg_r = 1'b1;
    chk("wr_ready", wr_ready_o, eg_w);
    chk("rd_gnt",   rd_gnt_o,   eg_r);

    if ((wv && !eg_w) || (rr && !eg_r)) m_stall_cnt++;

    // What the SRAM pins should show next cycle.
    exp_cen = 1'b1;
    exp_wen = 1'b1;
    exp_err = 1'b0;
    if (eg_w) begin
      m_wr_cnt++;
      if (int'(wa) < LEN) begin
        exp_cen     = 1'b0;
        exp_wen     = 1'b0;
        exp_addr    = wa;
        exp_data    = wd;
        ref_mem[wa] = wd;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (eg_r) begin
      m_rd_cnt++;
      if (int'(ra) < LEN) begin
        exp_cen  = 1'b0;
        exp_addr = ra;
        rdq.push_back('{due: cyc + 2, data: ref_mem[ra]});
      end else begin
        exp_err = 1'b1;
      end
    end

    // Starvation bookkeeping: writes that overtook a waiting reader.
    if (eg_r) begin
      m_pri    = 1'b0;
      m_streak = 0;
    end else if (!rr) begin
      m_streak = 0;
    end else if (eg_w) begin
      m_streak++;
      if (m_streak == BURST) m_pri = 1'b1;
    end

    last_wg = eg_w;
    last_rg = eg_r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Watchdog: the stimulus is a fixed number of cycles, so this only fires
  // if simulation time stops advancing as expected.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit            g [10];
    bit            rr_p;
    logic [AW-1:0] ra_p;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    rd_req_i   = 1'b0;
    rd_addr_i  = '0;
    model_reset();
    last_wg = 1'b0;
    last_rg = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // T2: both requesters held high -> W,W,W,W,R repeating.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, AW'(i % LEN), rnd_word(), 1'b1, AW'((i + 5) % LEN));
      g[i] = last_rg;
    end
`ifdef PSUM_ARB_PERF_EN
    // T6: counters after exactly those ten cycles.
    @(posedge clk);
    #1;
    chk("t6_wr_cnt",    wr_cnt_o,    16'd8);
    chk("t6_rd_cnt",    rd_cnt_o,    16'd2);
    chk("t6_stall_cnt", stall_cnt_o, 16'd10);
`endif
    for (int i = 0; i < 10; i++) chk("t2_pattern", g[i], (i % 5) == 4);
    idle(3);

    // T1: write then read the same word, back to back.
    step(1'b1, AW'(3), {COL{16'hA5A5}}, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, AW'(3));
    idle(3);

    // T3: sixteen back-to-back reads (12..15 lie outside the 12-word bank).
    for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b1, AW'(i));
    idle(3);

    // T4: reset one cycle after a read grant drops the read.
    step(1'b0, '0, '0, 1'b1, AW'(5));
    step(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    #1;
    chk_reset_values("t4");
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    model_reset();
    idle(4);

    // T5: out-of-range write and read are consumed but suppressed.
    step(1'b1, AW'(13), rnd_word(), 1'b0, '0);
    idle(2);
    step(1'b0, '0, '0, 1'b1, AW'(13));
    idle(3);

    // Randomised traffic; a read request is held until it is granted.
    rr_p = 1'b0;
    ra_p = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!rr_p && ($urandom_range(0, 1) == 1)) begin
        rr_p = 1'b1;
        ra_p = AW'($urandom_range(0, 15));
      end
      step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 15)), rnd_word(), rr_p, ra_p);
      if (last_rg) rr_p = 1'b0;
    end
    idle(4);
    chk("rdq_empty", rdq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
